// File: rtl/rc4_search_if.sv
// Bundle of start/done handshakes and RAM request buses between the RC4 search
// sequencer and its three phase engines.
interface rc4_search_if #(
    parameter int unsigned KEY_WIDTH = 24
);
    logic                 start;

    logic                 init_start;
    logic                 init_done;
    logic [7:0]           init_address;
    logic [7:0]           init_data;
    logic                 init_wren;

    logic                 start_scramble;
    logic                 done_scrambling;
    logic [7:0]           scr_address;
    logic [7:0]           scr_data;
    logic                 scr_wren;

    logic                 dec_start;
    logic                 dec_done;
    logic                 dec_msg_valid;
    logic [7:0]           dec_address;
    logic [7:0]           dec_data;
    logic                 dec_wren;

    logic [7:0]           ram_address;
    logic [7:0]           ram_data;
    logic                 ram_wren;

    logic [KEY_WIDTH-1:0] secret_key;
    logic                 busy;
    logic                 key_found;
    logic                 key_fail;

    modport master (
        input  start,
        output init_start,
        input  init_done, init_address, init_data, init_wren,
        output start_scramble,
        input  done_scrambling, scr_address, scr_data, scr_wren,
        output dec_start,
        input  dec_done, dec_msg_valid, dec_address, dec_data, dec_wren,
        output ram_address, ram_data, ram_wren,
        output secret_key, busy, key_found, key_fail
    );

    modport slave (
        output start,
        input  init_start,
        output init_done, init_address, init_data, init_wren,
        input  start_scramble,
        output done_scrambling, scr_address, scr_data, scr_wren,
        input  dec_start,
        output dec_done, dec_msg_valid, dec_address, dec_data, dec_wren,
        input  ram_address, ram_data, ram_wren,
        input  secret_key, busy, key_found, key_fail
    );
endinterface

// File: rtl/rc4_search_ctrl.sv
// RC4 key-search sequencer: runs init, scramble and decrypt per candidate key,
// owns the S-RAM port mux and stops on a valid message or an exhausted range.
module rc4_search_ctrl #(
    parameter int unsigned          KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MIN   = 24'h000000,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input logic          clk,
    input logic          reset,
    rc4_search_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StScramble,
        StDecrypt,
        StCheck,
        StFound,
        StFail
    } state_e;

    state_e               state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 valid_q, valid_d;
    // High only in the first cycle of a phase: drives the start pulse and masks done.
    logic                 first_q, first_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            key_q   <= KEY_MIN;
            valid_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        valid_d = valid_q;
        first_d = 1'b0;
        case (state_q)
            StIdle, StFound, StFail: begin
                if (bus.start) begin
                    state_d = StInit;
                    key_d   = KEY_MIN;
                    valid_d = 1'b0;
                    first_d = 1'b1;
                end
            end
            StInit: begin
                if (!first_q && bus.init_done) begin
                    state_d = StScramble;
                    first_d = 1'b1;
                end
            end
            StScramble: begin
                if (!first_q && bus.done_scrambling) begin
                    state_d = StDecrypt;
                    first_d = 1'b1;
                end
            end
            StDecrypt: begin
                if (!first_q && bus.dec_done) begin
                    valid_d = bus.dec_msg_valid;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (valid_q) begin
                    state_d = StFound;
                end else if (key_q == KEY_MAX) begin
                    state_d = StFail;
                end else begin
                    key_d   = key_q + 1'b1;
                    state_d = StInit;
                    first_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ram_address = 8'h00;
        bus.ram_data    = 8'h00;
        bus.ram_wren    = 1'b0;
        case (state_q)
            StInit: begin
                bus.ram_address = bus.init_address;
                bus.ram_data    = bus.init_data;
                bus.ram_wren    = bus.init_wren;
            end
            StScramble: begin
                bus.ram_address = bus.scr_address;
                bus.ram_data    = bus.scr_data;
                bus.ram_wren    = bus.scr_wren;
            end
            StDecrypt: begin
                bus.ram_address = bus.dec_address;
                bus.ram_data    = bus.dec_data;
                bus.ram_wren    = bus.dec_wren;
            end
            default: ;
        endcase
    end

    assign bus.init_start     = (state_q == StInit) && first_q;
    assign bus.start_scramble = (state_q == StScramble) && first_q;
    assign bus.dec_start      = (state_q == StDecrypt) && first_q;
    assign bus.secret_key     = key_q;
    assign bus.busy           = (state_q == StInit) || (state_q == StScramble) ||
                                (state_q == StDecrypt) || (state_q == StCheck);
    assign bus.key_found      = (state_q == StFound);
    assign bus.key_fail       = (state_q == StFail);

endmodule

// File: tb/tb_rc4_search_ctrl.sv
// Directed bench for rc4_search_ctrl: two instances (full range and a 0..2 range)
// driven by stub engines that answer 5 cycles after each start pulse.
module tb_rc4_search_ctrl;

    logic        clk;
    logic        rst_n;
    logic        clr    [2];
    logic        spur   [2];
    logic [23:0] target [2];
    logic [11:0] sigs;

    int tests = 0;
    int fails = 0;

    logic [23:0] keys [8];
    int          nkeys;

    rc4_search_if #(.KEY_WIDTH(24)) bus [2] ();

    rc4_search_ctrl #(
        .KEY_WIDTH(24),
        .KEY_MIN  (24'h000000),
        .KEY_MAX  (24'h3FFFFF)
    ) dut0 (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus[0])
    );

    rc4_search_ctrl #(
        .KEY_WIDTH(24),
        .KEY_MIN  (24'h000000),
        .KEY_MAX  (24'h000002)
    ) dut1 (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_stub
        logic [3:0] cnt;
        logic [1:0] eng;
        int         n_init, n_scr, n_dec;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= 4'd0;
                eng <= 2'd0;
            end else if (bus[g].init_start) begin
                cnt <= 4'd5;
                eng <= 2'd0;
            end else if (bus[g].start_scramble) begin
                cnt <= 4'd5;
                eng <= 2'd1;
            end else if (bus[g].dec_start) begin
                cnt <= 4'd5;
                eng <= 2'd2;
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end

        always @(posedge clk) begin
            if (clr[g]) begin
                n_init <= 0;
                n_scr  <= 0;
                n_dec  <= 0;
            end else begin
                if (bus[g].init_start)     n_init <= n_init + 1;
                if (bus[g].start_scramble) n_scr  <= n_scr + 1;
                if (bus[g].dec_start)      n_dec  <= n_dec + 1;
            end
        end

        assign bus[g].init_done       = (cnt == 4'd1) && (eng == 2'd0);
        assign bus[g].done_scrambling = ((cnt == 4'd1) && (eng == 2'd1)) || spur[g];
        assign bus[g].dec_done        = (cnt == 4'd1) && (eng == 2'd2);
        assign bus[g].dec_msg_valid   = (bus[g].secret_key == target[g]);
        assign bus[g].init_address    = 8'h11;
        assign bus[g].init_data       = 8'hA1;
        assign bus[g].init_wren       = 1'b1;
        assign bus[g].scr_address     = 8'h22;
        assign bus[g].scr_data        = 8'hB2;
        assign bus[g].scr_wren        = 1'b1;
        assign bus[g].dec_address     = 8'h33;
        assign bus[g].dec_data        = 8'hC3;
        assign bus[g].dec_wren        = 1'b1;
        assign sigs[g*6 +: 6] = {bus[g].dec_done, bus[g].key_fail, bus[g].key_found,
                                 bus[g].dec_start, bus[g].start_scramble,
                                 bus[g].init_start};
    end

    always @(posedge clk) begin
        if (clr[0]) begin
            nkeys <= 0;
        end else if (bus[0].init_start && nkeys < 8) begin
            keys[nkeys] <= bus[0].secret_key;
            nkeys       <= nkeys + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // sel: 0 init_start, 1 start_scramble, 2 dec_start, 3 key_found, 4 key_fail, 5 dec_done
    task automatic wait_for(input int g, input int sel, input int bound, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (sigs[g*6 + sel]) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic clear_counts(input int g);
        @(negedge clk);
        clr[g] = 1'b1;
        @(negedge clk);
        clr[g] = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        clr[0]        = 1'b0;
        clr[1]        = 1'b0;
        spur[0]       = 1'b0;
        spur[1]       = 1'b0;
        target[0]     = 24'h000000;
        target[1]     = 24'hFFFFFF;
        bus[0].start  = 1'b0;
        bus[1].start  = 1'b0;

        // Reset state
        #12;
        chk("rst_busy",  {31'd0, bus[0].busy}, 32'd0);
        chk("rst_found", {31'd0, bus[0].key_found}, 32'd0);
        chk("rst_fail",  {31'd0, bus[0].key_fail}, 32'd0);
        chk("rst_key",   {8'd0, bus[0].secret_key}, 32'd0);
        chk("rst_wren",  {31'd0, bus[0].ram_wren}, 32'd0);
        chk("rst_addr",  {24'd0, bus[0].ram_address}, 32'd0);
        chk("rst_pulse", {29'd0, bus[0].init_start, bus[0].start_scramble, bus[0].dec_start},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts(0);
        clear_counts(1);

        // Test 1: valid on first key, mux per phase, spurious scramble done in INIT
        bus[0].start = 1'b1;
        @(posedge clk);
        #1;
        chk("t1_init_pulse", {31'd0, bus[0].init_start}, 32'd1);
        chk("t1_busy",       {31'd0, bus[0].busy}, 32'd1);
        chk("t1_init_addr",  {24'd0, bus[0].ram_address}, 32'h11);
        chk("t1_init_data",  {24'd0, bus[0].ram_data}, 32'hA1);
        @(negedge clk);
        bus[0].start = 1'b0;
        spur[0]      = 1'b1;
        @(negedge clk);
        spur[0] = 1'b0;
        chk("t1_spur_ignored", {24'd0, bus[0].ram_address}, 32'h11);
        wait_for(0, 1, 40, "t1_wait_scr");
        chk("t1_scr_addr", {24'd0, bus[0].ram_address}, 32'h22);
        chk("t1_scr_data", {24'd0, bus[0].ram_data}, 32'hB2);
        wait_for(0, 2, 40, "t1_wait_dec");
        chk("t1_dec_addr", {24'd0, bus[0].ram_address}, 32'h33);
        chk("t1_dec_wren", {31'd0, bus[0].ram_wren}, 32'd1);
        wait_for(0, 5, 40, "t1_wait_dec_done");
        @(posedge clk);
        #1;
        chk("t1_check_wren", {31'd0, bus[0].ram_wren}, 32'd0);
        chk("t1_check_busy", {31'd0, bus[0].busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("t1_found",   {31'd0, bus[0].key_found}, 32'd1);
        chk("t1_busy0",   {31'd0, bus[0].busy}, 32'd0);
        chk("t1_key",     {8'd0, bus[0].secret_key}, 32'd0);
        chk("t1_n_init",  g_stub[0].n_init, 32'd1);
        chk("t1_n_scr",   g_stub[0].n_scr, 32'd1);
        chk("t1_n_dec",   g_stub[0].n_dec, 32'd1);
        chk("t1_idle_wren", {31'd0, bus[0].ram_wren}, 32'd0);
        repeat (10) @(negedge clk);
        chk("t1_found_hold", {31'd0, bus[0].key_found}, 32'd1);

        // Test 2: start from FOUND restarts; valid only at key 3; start in DECRYPT ignored
        clear_counts(0);
        target[0]    = 24'h000003;
        bus[0].start = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_found_clr",  {31'd0, bus[0].key_found}, 32'd0);
        chk("t2_init_pulse", {31'd0, bus[0].init_start}, 32'd1);
        chk("t2_key0",       {8'd0, bus[0].secret_key}, 32'd0);
        @(negedge clk);
        bus[0].start = 1'b0;
        wait_for(0, 2, 40, "t2_wait_dec");
        bus[0].start = 1'b1;
        @(negedge clk);
        bus[0].start = 1'b0;
        chk("t2_start_ignored", {24'd0, bus[0].ram_address}, 32'h33);
        chk("t2_no_restart",    g_stub[0].n_init, 32'd1);
        wait_for(0, 3, 400, "t2_wait_found");
        chk("t2_passes", g_stub[0].n_init, 32'd4);
        chk("t2_n_dec",  g_stub[0].n_dec, 32'd4);
        chk("t2_nkeys",  nkeys, 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_key_seq%0d", i), {8'd0, keys[i]}, i);
        chk("t2_key3",   {8'd0, bus[0].secret_key}, 32'd3);
        chk("t2_fail0",  {31'd0, bus[0].key_fail}, 32'd0);

        // Test 3: range 0..2 never valid -> fail after three passes
        bus[1].start = 1'b1;
        @(negedge clk);
        bus[1].start = 1'b0;
        wait_for(1, 4, 400, "t3_wait_fail");
        chk("t3_passes", g_stub[1].n_init, 32'd3);
        chk("t3_key",    {8'd0, bus[1].secret_key}, 32'd2);
        chk("t3_busy",   {31'd0, bus[1].busy}, 32'd0);
        chk("t3_found0", {31'd0, bus[1].key_found}, 32'd0);
        repeat (20) @(negedge clk);
        chk("t3_no_4th", g_stub[1].n_init, 32'd3);
        chk("t3_hold",   {31'd0, bus[1].key_fail}, 32'd1);

        // Test 4: reset during the second key's SCRAMBLE aborts immediately
        target[0]    = 24'hFFFFFF;
        bus[0].start = 1'b1;
        @(negedge clk);
        bus[0].start = 1'b0;
        wait_for(0, 1, 40, "t4_wait_scr_a");
        wait_for(0, 1, 40, "t4_wait_scr_b");
        @(negedge clk);
        chk("t4_key1", {8'd0, bus[0].secret_key}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_key",  {8'd0, bus[0].secret_key}, 32'd0);
        chk("t4_rst_busy", {31'd0, bus[0].busy}, 32'd0);
        chk("t4_rst_addr", {24'd0, bus[0].ram_address}, 32'd0);
        chk("t4_rst_wren", {31'd0, bus[0].ram_wren}, 32'd0);
        chk("t4_rst_fail", {31'd0, bus[1].key_fail}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_idle_busy", {31'd0, bus[0].busy}, 32'd0);
        bus[0].start = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_restart_pulse", {31'd0, bus[0].init_start}, 32'd1);
        chk("t4_restart_key",   {8'd0, bus[0].secret_key}, 32'd0);
        @(negedge clk);
        bus[0].start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rc4_search_ctrl.md
# rc4_search_ctrl

Top-level sequencer for the RC4 key-search datapath. It runs the three phase engines in order for each candidate key: S-memory init, key scheduling (scramble) and decrypt/PRGA. It owns the single-port S-RAM and multiplexes it to whichever engine is active. After each decrypt it checks the engine's message-valid verdict and either stops with the key or advances to the next key, until the key range is exhausted.

## Interface
- KEY_WIDTH, 24, width of secret_key
- KEY_MIN, 24'h000000, first candidate key
- KEY_MAX, 24'h3FFFFF, last candidate key (inclusive)
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin search from KEY_MIN; sampled in IDLE, FOUND, FAIL only
- init_start  out  1  one-cycle start pulse to S-init engine
- init_done  in  1  S-init complete
- init_address / init_data  in  8 / 8  S-init RAM request
- init_wren  in  1  S-init write enable
- start_scramble  out  1  one-cycle start pulse to scramble engine
- done_scrambling  in  1  scramble complete
- scr_address / scr_data  in  8 / 8  scramble RAM request
- scr_wren  in  1  scramble write enable
- dec_start  out  1  one-cycle start pulse to decrypt engine
- dec_done  in  1  decrypt complete
- dec_msg_valid  in  1  decrypted text valid; qualified by dec_done
- dec_address / dec_data  in  8 / 8  decrypt RAM request
- dec_wren  in  1  decrypt write enable
- ram_address / ram_data  out  8 / 8  S-RAM port
- ram_wren  out  1  S-RAM write enable
- secret_key  out  KEY_WIDTH  current candidate, to scramble and decrypt engines
- busy  out  1  high in INIT, SCRAMBLE, DECRYPT, CHECK
- key_found  out  1  search succeeded; secret_key holds the key
- key_fail  out  1  range exhausted without a valid key

## Operation
- States: IDLE, INIT, SCRAMBLE, DECRYPT, CHECK, FOUND, FAIL.
- IDLE/FOUND/FAIL with start=1: load key=KEY_MIN, clear flags, go to INIT.
- INIT: init_start=1 on first cycle only. On init_done, go to SCRAMBLE.
- SCRAMBLE: start_scramble=1 on first cycle only. On done_scrambling, go to DECRYPT.
- DECRYPT: dec_start=1 on first cycle only. On dec_done, latch dec_msg_valid and go to CHECK.
- CHECK (one cycle):
  - If the latched valid bit is set, go to FOUND.
  - Else if key==KEY_MAX, go to FAIL.
  - Else key<=key+1 and go to INIT.
- RAM mux (combinational from state register):
  - INIT selects init_*; SCRAMBLE selects scr_*; DECRYPT selects dec_*.
  - All other states drive ram_address=0, ram_data=0, ram_wren=0.
- ram_q is not routed through this block; it fans out directly to the engines.
- A done input asserted during the start-pulse cycle is ignored. Done is accepted from the second cycle of a phase onward.
- Done inputs of inactive engines are ignored.
- start while busy is ignored.
- key increment is unsigned KEY_WIDTH and never wraps; KEY_MAX terminates.
- secret_key changes only on the CHECK->INIT edge or on start, so it is stable for a whole pass.

## Timing
- Reset values: state IDLE, secret_key=KEY_MIN, all start pulses 0, ram_* 0, busy 0, key_found 0, key_fail 0.
- Reset asserted mid-search aborts immediately. All outputs take reset values asynchronously, and engines see no further start pulses.
- start sampled at edge t: state=INIT and init_start=1 in cycle t+1.
- Phase done sampled at edge t: next phase state and its start pulse appear in cycle t+1.
- dec_done at edge t: CHECK in t+1. The next INIT (new key, init_start=1) or FOUND/FAIL follows in t+2.
- Controller overhead per candidate: 3 cycles plus engine latencies.
- key_found/key_fail rise on entry to FOUND/FAIL. They hold until start or reset.
- busy is 0 in FOUND/FAIL.
- Exactly one start pulse is issued per phase per candidate.

## Test plan
- Reset, then start with stub engines (done 5 cycles after pulse) and dec_msg_valid=1 on first key -> one pulse each of init_start, start_scramble, dec_start in order; key_found=1, secret_key=0, busy=0.
- Valid only at key 3 -> exactly 4 passes; secret_key steps 0,1,2,3; key_found=1 with secret_key=3.
- KEY_MIN=0, KEY_MAX=2, never valid -> 3 passes then key_fail=1, secret_key=2, no fourth init_start.
- Mux check: drive distinct address/data/wren per engine (e.g. 8'h11/8'h22/8'h33) -> ram_* tracks only the active phase; ram_wren=0 in IDLE/CHECK. Spurious done_scrambling during INIT -> ignored.
- Assert reset during SCRAMBLE -> outputs go to reset values immediately; the next start restarts at KEY_MIN with init_start.
- start pulsed during DECRYPT -> ignored. start in FOUND -> flags clear and search restarts at KEY_MIN.
